// File: rtl/fir4_pkg.sv
// Shared definitions for the 4-tap smoothing encoder/decoder pair:
// default widths, encoder tap weights and the decoder state encoding.
package fir4_pkg;

  localparam int XW_DEF = 4;
  localparam int YW_DEF = XW_DEF + 3;

  // y[n] = TAP0*x[n] + TAP1*x[n-1] + TAP2*x[n-2] + TAP3*x[n-3]
  localparam int TAP0 = 2;
  localparam int TAP1 = 1;
  localparam int TAP2 = 1;
  localparam int TAP3 = 1;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } dec_state_e;

endpackage

// File: rtl/fir4_hist.sv
// Three-deep history of reconstructed samples with shift enable, sync clear
// and the running sum s = h1 + h2 + h3.
module fir4_hist #(
  parameter int XW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          shift,
  input  logic [XW-1:0] d,
  output logic [XW+1:0] s
);

  logic [XW-1:0] h1_p1, h2_p1, h3_p1;

  always_ff @(posedge clk) begin
    if (clr) begin
      h1_p1 <= '0;
      h2_p1 <= '0;
      h3_p1 <= '0;
    end else if (shift) begin
      h3_p1 <= h2_p1;
      h2_p1 <= h1_p1;
      h1_p1 <= d;
    end
  end

  assign s = {2'b00, h1_p1} + {2'b00, h2_p1} + {2'b00, h3_p1};

endmodule

// File: rtl/fir4_deconv.sv
// Receive-side inverse of the 4-tap smoothing encoder: recovers x from y using
// its own reconstructed history, flags undecodable samples with a sticky error.
module fir4_deconv
  import fir4_pkg::*;
#(
  parameter int XW   = XW_DEF,
  parameter int YW   = XW + 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [YW-1:0]   y,
  input  logic            y_valid,
  output logic            y_ready,
  input  logic            resync,
  output logic [XW-1:0]   x,
  output logic            x_valid,
  input  logic            x_ready,
  output logic            err,
  output logic [CNTW-1:0] dec_cnt
);

  localparam logic signed [YW:0] X_MAX = {{(YW + 1 - XW){1'b0}}, {XW{1'b1}}};

  // A residual is decodable only if it is non-negative, even, and halves into range.
  function automatic logic is_legal(input logic signed [YW:0] r);
    logic signed [YW:0] half;
    half = r >>> 1;
    return !r[YW] && !r[0] && (half <= X_MAX);
  endfunction

  dec_state_e        state_p1, state_nx;
  logic              vld_p1, vld_nx;
  logic              err_p1, err_nx;
  logic [XW-1:0]     x_p1;
  logic [CNTW-1:0]   cnt_p1;
  logic [XW+1:0]     s_sum;
  logic signed [YW:0] r_p0;
  logic              legal_p0;
  logic              y_xfer;
  logic              x_ld;
  logic              hist_shift;

  // Stage 0: combinational decode of the accepted sample
  assign y_ready  = (state_p1 == ERR) | ~vld_p1 | x_ready;
  assign y_xfer   = y_valid & y_ready;
  assign r_p0     = $signed({1'b0, y}) - $signed({{(YW - XW - 1){1'b0}}, s_sum});
  assign legal_p0 = is_legal(r_p0);

  fir4_hist #(.XW(XW)) u_hist (
    .clk   (clk),
    .clr   (rst | resync),
    .shift (hist_shift),
    .d     (r_p0[XW:1]),
    .s     (s_sum)
  );

  always_comb begin
    state_nx   = state_p1;
    vld_nx     = vld_p1 & ~x_ready;
    err_nx     = err_p1;
    x_ld       = 1'b0;
    hist_shift = 1'b0;
    if (resync) begin
      state_nx = RUN;
      vld_nx   = 1'b0;
      err_nx   = 1'b0;
    end else if (y_xfer && state_p1 == RUN) begin
      if (legal_p0) begin
        x_ld       = 1'b1;
        vld_nx     = 1'b1;
        hist_shift = 1'b1;
      end else begin
        state_nx = ERR;
        err_nx   = 1'b1;
        vld_nx   = 1'b0;
      end
    end
  end

  // Stage 1: registered output, state and delivered-sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= RUN;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      x_p1     <= '0;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_nx;
      vld_p1   <= vld_nx;
      err_p1   <= err_nx;
      if (x_ld) x_p1 <= r_p0[XW:1];
      if (vld_p1 && x_ready) cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  assign x       = x_p1;
  assign x_valid = vld_p1;
  assign err     = err_p1;
  assign dec_cnt = cnt_p1;

endmodule
